// File: rtl/dcm_clkgen_programmer.sv
// dcm_clkgen_programmer
//   Run-time frequency controller for a DCM_CLKGEN synthesizer
//   (CLKFX = CLKIN * M / D). It shifts new M/D values out on
//   progen/progdata, issues GO, waits for PROGDONE and then LOCKED, and
//   reports the result. It can optionally recover a DCM that loses lock
//   while the controller is idle.
//
//   'clock' is the same net as the DCM PROGCLK, so progen/progdata are
//   launched directly from this domain.
//
// Ports
//   clock         in   controller clock / DCM PROGCLK
//   reset_n       in   asynchronous active-low reset
//   start         in   program request (ignored while busy)
//   multiply[8:0] in   M, legal 2..256
//   divide[8:0]   in   D, legal 1..256
//   busy          out  sequence in progress
//   done          out  one-cycle pulse: programmed and locked
//   error         out  sticky fault flag, cleared by the next legal start
//   error_code    out  0 none, 1 illegal M/D, 2 PROGDONE timeout, 3 LOCKED timeout
//   progen        out  DCM PROGEN
//   progdata      out  DCM PROGDATA
//   dcm_reset     out  DCM RST (active high)
//   dcm_locked    in   DCM LOCKED (asynchronous, synchronised here)
//   dcm_progdone  in   DCM PROGDONE (synchronous to PROGCLK)
//
// state     | meaning
// ----------+------------------------------------------------------
// IDLE      | waiting for start or lock loss
// LOAD_D    | 10 cycles: header 1,0 then d[0]..d[7]
// GAP1      | progen low between LOAD_D and LOAD_M
// LOAD_M    | 10 cycles: header 1,1 then m[0]..m[7]
// GAP2      | progen low between LOAD_M and GO
// GO        | one-cycle GO command (progen=1, progdata=0)
// WAIT_DONE | waiting for PROGDONE to go low then high
// WAIT_LOCK | waiting for synchronised LOCKED
// DONE      | done pulse
// FAIL      | error flagged, back to IDLE
// RECOVER   | dcm_reset pulse after lock loss while idle

module dcm_clkgen_programmer #(
    parameter int GAP_CYCLES     = 2,
    parameter int TIMEOUT_CYCLES = 65535,
    parameter int RESET_CYCLES   = 8,
    parameter bit AUTO_RECOVER   = 1'b1
) (
    input  logic       clock,
    input  logic       reset_n,
    input  logic       start,
    input  logic [8:0] multiply,
    input  logic [8:0] divide,
    output logic       busy,
    output logic       done,
    output logic       error,
    output logic [1:0] error_code,
    output logic       progen,
    output logic       progdata,
    output logic       dcm_reset,
    input  logic       dcm_locked,
    input  logic       dcm_progdone
);

    typedef enum logic [3:0] {
        IDLE      = 4'd0,
        LOAD_D    = 4'd1,
        GAP1      = 4'd2,
        LOAD_M    = 4'd3,
        GAP2      = 4'd4,
        GO        = 4'd5,
        WAIT_DONE = 4'd6,
        WAIT_LOCK = 4'd7,
        DONE      = 4'd8,
        FAIL      = 4'd9,
        RECOVER   = 4'd10
    } state_t;

    localparam logic [15:0] LOAD_LAST = 16'd9;
    localparam logic [15:0] GAP_LAST  = 16'(GAP_CYCLES - 1);
    localparam logic [15:0] TO_LAST   = 16'(TIMEOUT_CYCLES - 1);
    localparam logic [15:0] RST_LAST  = 16'(RESET_CYCLES - 1);

    state_t      state;
    state_t      state_next;
    logic [15:0] cnt;
    logic [7:0]  m_reg;
    logic [7:0]  d_reg;
    logic        locked_meta;
    logic        locked_sync;
    logic        locked_prev;
    logic        lock_fall;
    logic        seen_low;
    logic        operands_ok;
    logic        capture;
    logic        err_load;
    logic        err_next;
    logic [1:0]  code_next;
    logic [9:0]  shift_word;

    assign operands_ok = (multiply >= 9'd2) && (multiply <= 9'd256) &&
                         (divide >= 9'd1) && (divide <= 9'd256);

    assign lock_fall = locked_prev & ~locked_sync;

    // Next-state and error bookkeeping
    always_comb begin
        state_next = state;
        capture    = 1'b0;
        err_load   = 1'b0;
        err_next   = 1'b0;
        code_next  = 2'd0;
        case (state)
            IDLE: begin
                // start takes priority over a simultaneous lock loss: the
                // program sequence ends in a relock wait anyway
                if (start) begin
                    err_load = 1'b1;
                    if (operands_ok) begin
                        capture    = 1'b1;
                        state_next = LOAD_D;
                    end else begin
                        err_next  = 1'b1;
                        code_next = 2'd1;
                    end
                end else if (AUTO_RECOVER && lock_fall) begin
                    state_next = RECOVER;
                end
            end
            LOAD_D:    if (cnt == LOAD_LAST) state_next = GAP1;
            GAP1:      if (cnt == GAP_LAST)  state_next = LOAD_M;
            LOAD_M:    if (cnt == LOAD_LAST) state_next = GAP2;
            GAP2:      if (cnt == GAP_LAST)  state_next = GO;
            GO:        state_next = WAIT_DONE;
            WAIT_DONE: begin
                if (seen_low && dcm_progdone) begin
                    state_next = WAIT_LOCK;
                end else if (cnt >= TO_LAST) begin
                    state_next = FAIL;
                    err_load   = 1'b1;
                    err_next   = 1'b1;
                    code_next  = 2'd2;
                end
            end
            WAIT_LOCK: begin
                if (locked_sync) begin
                    state_next = DONE;
                end else if (cnt >= TO_LAST) begin
                    state_next = FAIL;
                    err_load   = 1'b1;
                    err_next   = 1'b1;
                    code_next  = 2'd3;
                end
            end
            DONE:      state_next = IDLE;
            FAIL:      state_next = IDLE;
            RECOVER:   if (cnt == RST_LAST) state_next = WAIT_LOCK;
            default:   state_next = IDLE;
        endcase
    end

    // Outputs decode from state only, so an asynchronous reset drops the
    // DCM pins immediately.
    always_comb begin
        busy       = 1'b0;
        done       = 1'b0;
        progen     = 1'b0;
        progdata   = 1'b0;
        dcm_reset  = 1'b0;
        shift_word = 10'd0;
        case (state)
            LOAD_D: begin
                busy       = 1'b1;
                progen     = 1'b1;
                shift_word = {d_reg, 2'b01} >> cnt[3:0];
                progdata   = shift_word[0];
            end
            LOAD_M: begin
                busy       = 1'b1;
                progen     = 1'b1;
                shift_word = {m_reg, 2'b11} >> cnt[3:0];
                progdata   = shift_word[0];
            end
            GAP1, GAP2, WAIT_DONE, WAIT_LOCK: busy = 1'b1;
            GO: begin
                busy   = 1'b1;
                progen = 1'b1;
            end
            RECOVER: begin
                busy      = 1'b1;
                dcm_reset = 1'b1;
            end
            DONE:    done = 1'b1;
            default: ;
        endcase
    end

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            state <= IDLE;
        end else begin
            state <= state_next;
        end
    end

    // Phase/timeout counter: clears on every state change, saturates.
    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            cnt <= 16'd0;
        end else if (state_next != state) begin
            cnt <= 16'd0;
        end else if (cnt != 16'hFFFF) begin
            cnt <= cnt + 16'd1;
        end
    end

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            m_reg <= 8'd0;
            d_reg <= 8'd0;
        end else if (capture) begin
            m_reg <= 8'(multiply - 9'd1);
            d_reg <= 8'(divide - 9'd1);
        end
    end

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            error      <= 1'b0;
            error_code <= 2'd0;
        end else if (err_load) begin
            error      <= err_next;
            error_code <= code_next;
        end
    end

    // PROGDONE must be seen low inside WAIT_DONE before its rise counts,
    // so a level left high from the previous programming is not mistaken
    // for completion.
    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            seen_low <= 1'b0;
        end else begin
            seen_low <= (state == WAIT_DONE) ? (seen_low | ~dcm_progdone) : 1'b0;
        end
    end

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            locked_meta <= 1'b0;
            locked_sync <= 1'b0;
            locked_prev <= 1'b0;
        end else begin
            locked_meta <= dcm_locked;
            locked_sync <= locked_meta;
            locked_prev <= locked_sync;
        end
    end

endmodule

// File: tb/tb_dcm_clkgen_programmer.sv
// Directed bench for dcm_clkgen_programmer. A second instance with
// AUTO_RECOVER=0 shares all inputs so lock-loss behaviour can be
// compared between the two builds.

module tb_dcm_clkgen_programmer;

    logic       clock = 1'b0;
    logic       reset_n;
    logic       start;
    logic [8:0] multiply;
    logic [8:0] divide;
    logic       dcm_locked;
    logic       dcm_progdone;

    logic       busy, done, error, progen, progdata, dcm_reset;
    logic [1:0] error_code;
    logic       busy_nr, done_nr, error_nr, progen_nr, progdata_nr, dcm_reset_nr;
    logic [1:0] error_code_nr;

    int tests_run    = 0;
    int tests_failed = 0;

    dcm_clkgen_programmer #(
        .GAP_CYCLES(2), .TIMEOUT_CYCLES(100), .RESET_CYCLES(8), .AUTO_RECOVER(1'b1)
    ) dut (
        .clock(clock), .reset_n(reset_n), .start(start),
        .multiply(multiply), .divide(divide),
        .busy(busy), .done(done), .error(error), .error_code(error_code),
        .progen(progen), .progdata(progdata), .dcm_reset(dcm_reset),
        .dcm_locked(dcm_locked), .dcm_progdone(dcm_progdone)
    );

    dcm_clkgen_programmer #(
        .GAP_CYCLES(2), .TIMEOUT_CYCLES(100), .RESET_CYCLES(8), .AUTO_RECOVER(1'b0)
    ) dut_nr (
        .clock(clock), .reset_n(reset_n), .start(start),
        .multiply(multiply), .divide(divide),
        .busy(busy_nr), .done(done_nr), .error(error_nr), .error_code(error_code_nr),
        .progen(progen_nr), .progdata(progdata_nr), .dcm_reset(dcm_reset_nr),
        .dcm_locked(dcm_locked), .dcm_progdone(dcm_progdone)
    );

    always #5 clock = ~clock;

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    task automatic step();
        @(posedge clock);
        #1;
    endtask

    task automatic apply_reset();
        reset_n = 1'b0;
        start   = 1'b0;
        step();
        step();
        reset_n = 1'b1;
        step();
    endtask

    task automatic test_reset();
        reset_n      = 1'b0;
        start        = 1'b0;
        multiply     = 9'd0;
        divide       = 9'd0;
        dcm_locked   = 1'b1;
        dcm_progdone = 1'b1;
        #3;
        tests_run++;
        if ({busy, done, error, error_code, progen, progdata, dcm_reset} !== 8'b0) begin
            tests_failed++;
            $display("FAIL reset_outputs: got %b expected 00000000",
                     {busy, done, error, error_code, progen, progdata, dcm_reset});
        end
        step();
        step();
        reset_n = 1'b1;
        step();
        step();
        step();
        tests_run++;
        if ({busy, done, error, progen, dcm_reset} !== 5'b0) begin
            tests_failed++;
            $display("FAIL reset_release_idle: got %b expected 00000",
                     {busy, done, error, progen, dcm_reset});
        end
    endtask

    task automatic test_program();
        logic [9:0] exp_d = 10'b0000001101;
        logic [9:0] exp_m = 10'b0000100111;
        logic [9:0] got_d, got_m;
        logic       pen_bad = 1'b0;
        logic       gap_bad = 1'b0;
        logic       busy_bad = 1'b0;
        int         n;
        dcm_progdone = 1'b1;
        dcm_locked   = 1'b1;
        multiply = 9'd10;
        divide   = 9'd4;
        start    = 1'b1;
        step();
        start = 1'b0;
        for (int i = 0; i < 10; i++) begin
            got_d[i] = progdata;
            if (progen !== 1'b1 || busy !== 1'b1) pen_bad = 1'b1;
            step();
        end
        for (int i = 0; i < 2; i++) begin
            if ({progen, progdata} !== 2'b00 || busy !== 1'b1) gap_bad = 1'b1;
            step();
        end
        for (int i = 0; i < 10; i++) begin
            got_m[i] = progdata;
            if (progen !== 1'b1 || busy !== 1'b1) pen_bad = 1'b1;
            step();
        end
        for (int i = 0; i < 2; i++) begin
            if ({progen, progdata} !== 2'b00 || busy !== 1'b1) gap_bad = 1'b1;
            step();
        end
        tests_run++;
        if ({progen, progdata, busy} !== 3'b101) begin
            tests_failed++;
            $display("FAIL prog_go: got progen,progdata,busy=%b expected 101",
                     {progen, progdata, busy});
        end
        tests_run++;
        if (got_d !== exp_d) begin
            tests_failed++;
            $display("FAIL prog_d_bits: got %b expected %b", got_d, exp_d);
        end
        tests_run++;
        if (got_m !== exp_m) begin
            tests_failed++;
            $display("FAIL prog_m_bits: got %b expected %b", got_m, exp_m);
        end
        tests_run++;
        if (pen_bad !== 1'b0 || gap_bad !== 1'b0) begin
            tests_failed++;
            $display("FAIL prog_progen_shape: got load_bad=%b gap_bad=%b expected 0 0",
                     pen_bad, gap_bad);
        end
        step();
        dcm_progdone = 1'b0;
        dcm_locked   = 1'b0;
        for (int i = 0; i < 3; i++) begin
            if (progen !== 1'b0 || busy !== 1'b1) busy_bad = 1'b1;
            step();
        end
        dcm_progdone = 1'b1;
        step();
        step();
        dcm_locked = 1'b1;
        n = 0;
        while (done !== 1'b1 && n < 20) begin
            if (busy !== 1'b1) busy_bad = 1'b1;
            step();
            n++;
        end
        tests_run++;
        if (done !== 1'b1 || busy !== 1'b0 || error !== 1'b0) begin
            tests_failed++;
            $display("FAIL prog_done: got done,busy,error=%b after %0d cycles expected 100",
                     {done, busy, error}, n);
        end
        tests_run++;
        if (busy_bad !== 1'b0) begin
            tests_failed++;
            $display("FAIL prog_busy_wait: got busy dropped early=%b expected 0", busy_bad);
        end
        step();
        tests_run++;
        if (done !== 1'b0) begin
            tests_failed++;
            $display("FAIL prog_done_pulse: got done=%b one cycle later expected 0", done);
        end
    endtask

    task automatic test_illegal();
        logic [8:0] ms [4] = '{9'd1, 9'd257, 9'd10, 9'd10};
        logic [8:0] ds [4] = '{9'd4, 9'd4, 9'd0, 9'd257};
        logic       pen_seen;
        for (int k = 0; k < 4; k++) begin
            multiply = ms[k];
            divide   = ds[k];
            start    = 1'b1;
            step();
            start = 1'b0;
            tests_run++;
            if ({error, error_code, busy} !== 4'b1010) begin
                tests_failed++;
                $display("FAIL illegal_%0d: got error,code,busy=%b expected 1010",
                         k, {error, error_code, busy});
            end
            pen_seen = 1'b0;
            for (int i = 0; i < 4; i++) begin
                if (progen !== 1'b0 || progdata !== 1'b0 || dcm_reset !== 1'b0 || busy !== 1'b0)
                    pen_seen = 1'b1;
                step();
            end
            tests_run++;
            if (pen_seen !== 1'b0 || error !== 1'b1) begin
                tests_failed++;
                $display("FAIL illegal_quiet_%0d: got pins_toggled=%b error=%b expected 0 1",
                         k, pen_seen, error);
            end
        end
        multiply = 9'd2;
        divide   = 9'd1;
        start    = 1'b1;
        step();
        start = 1'b0;
        tests_run++;
        if ({error, error_code, busy} !== 4'b0001) begin
            tests_failed++;
            $display("FAIL illegal_clear: got error,code,busy=%b expected 0001",
                     {error, error_code, busy});
        end
        apply_reset();
    endtask

    task automatic test_timeout();
        logic early_bad = 1'b0;
        dcm_progdone = 1'b0;
        dcm_locked   = 1'b1;
        multiply = 9'd4;
        divide   = 9'd2;
        start    = 1'b1;
        step();
        start = 1'b0;
        for (int i = 0; i < 24; i++) step();
        tests_run++;
        if ({progen, progdata} !== 2'b10) begin
            tests_failed++;
            $display("FAIL timeout_go_latency: got progen,progdata=%b at cycle 25 expected 10",
                     {progen, progdata});
        end
        step();
        for (int i = 0; i < 99; i++) begin
            step();
            if (error !== 1'b0 || busy !== 1'b1) early_bad = 1'b1;
        end
        tests_run++;
        if (early_bad !== 1'b0) begin
            tests_failed++;
            $display("FAIL timeout_early: got early error/idle=%b expected 0", early_bad);
        end
        step();
        tests_run++;
        if ({error, error_code, busy} !== 4'b1100) begin
            tests_failed++;
            $display("FAIL timeout_code2: got error,code,busy=%b expected 1100",
                     {error, error_code, busy});
        end
        step();
        step();
        tests_run++;
        if ({error, error_code} !== 3'b110) begin
            tests_failed++;
            $display("FAIL timeout_sticky: got error,code=%b expected 110", {error, error_code});
        end
        dcm_progdone = 1'b1;
        apply_reset();
    endtask

    task automatic test_recover();
        logic nr_bad = 1'b0;
        logic busy_bad = 1'b0;
        int   n;
        dcm_progdone = 1'b1;
        dcm_locked   = 1'b1;
        for (int i = 0; i < 4; i++) step();
        dcm_locked = 1'b0;
        n = 0;
        while (dcm_reset !== 1'b1 && n < 10) begin
            if (dcm_reset_nr !== 1'b0 || busy_nr !== 1'b0) nr_bad = 1'b1;
            step();
            n++;
        end
        tests_run++;
        if (dcm_reset !== 1'b1) begin
            tests_failed++;
            $display("FAIL recover_start: got dcm_reset=%b after %0d cycles expected 1",
                     dcm_reset, n);
        end
        n = 0;
        while (dcm_reset === 1'b1 && n < 20) begin
            if (busy !== 1'b1 || progen !== 1'b0) busy_bad = 1'b1;
            if (dcm_reset_nr !== 1'b0 || busy_nr !== 1'b0) nr_bad = 1'b1;
            step();
            n++;
        end
        tests_run++;
        if (n != 8) begin
            tests_failed++;
            $display("FAIL recover_width: got %0d cycles of dcm_reset expected 8", n);
        end
        dcm_locked = 1'b1;
        n = 0;
        while (done !== 1'b1 && n < 20) begin
            if (busy !== 1'b1) busy_bad = 1'b1;
            if (dcm_reset_nr !== 1'b0 || busy_nr !== 1'b0) nr_bad = 1'b1;
            step();
            n++;
        end
        tests_run++;
        if (done !== 1'b1 || busy_bad !== 1'b0 || error !== 1'b0) begin
            tests_failed++;
            $display("FAIL recover_done: got done=%b busy_bad=%b error=%b expected 1 0 0",
                     done, busy_bad, error);
        end
        step();
        tests_run++;
        if (nr_bad !== 1'b0 || done_nr !== 1'b0) begin
            tests_failed++;
            $display("FAIL recover_disabled: got noauto activity=%b expected 0", nr_bad);
        end
    endtask

    task automatic test_back_to_back();
        logic [9:0] exp_d = 10'b0000000001;
        logic [9:0] exp_m = 10'b1111111111;
        logic [9:0] got_d, got_m;
        apply_reset();
        multiply = 9'd256;
        divide   = 9'd1;
        start    = 1'b1;
        step();
        start = 1'b0;
        for (int i = 0; i < 10; i++) begin
            got_d[i] = progdata;
            if (i == 1) begin
                start    = 1'b1;
                multiply = 9'd2;
                divide   = 9'd256;
            end else begin
                start = 1'b0;
            end
            step();
        end
        step();
        step();
        for (int i = 0; i < 10; i++) begin
            got_m[i] = progdata;
            step();
        end
        tests_run++;
        if (got_d !== exp_d) begin
            tests_failed++;
            $display("FAIL b2b_d_bits: got %b expected %b", got_d, exp_d);
        end
        tests_run++;
        if (got_m !== exp_m) begin
            tests_failed++;
            $display("FAIL b2b_m_bits: got %b expected %b", got_m, exp_m);
        end
        apply_reset();
    endtask

    task automatic test_reset_mid();
        logic pen_seen = 1'b0;
        multiply = 9'd10;
        divide   = 9'd4;
        start    = 1'b1;
        step();
        start = 1'b0;
        for (int i = 0; i < 15; i++) step();
        tests_run++;
        if (progen !== 1'b1 || busy !== 1'b1) begin
            tests_failed++;
            $display("FAIL midreset_in_load_m: got progen,busy=%b expected 11", {progen, busy});
        end
        reset_n = 1'b0;
        #1;
        tests_run++;
        if ({progen, progdata, dcm_reset, busy} !== 4'b0000) begin
            tests_failed++;
            $display("FAIL midreset_async: got progen,progdata,dcm_reset,busy=%b expected 0000",
                     {progen, progdata, dcm_reset, busy});
        end
        step();
        reset_n = 1'b1;
        step();
        for (int i = 0; i < 12; i++) begin
            if (progen !== 1'b0 || busy !== 1'b0) pen_seen = 1'b1;
            step();
        end
        tests_run++;
        if (pen_seen !== 1'b0 || error !== 1'b0 || done !== 1'b0) begin
            tests_failed++;
            $display("FAIL midreset_abandoned: got activity=%b error=%b done=%b expected 0 0 0",
                     pen_seen, error, done);
        end
    endtask

    initial begin
        test_reset();
        test_program();
        test_illegal();
        test_timeout();
        test_recover();
        test_back_to_back();
        test_reset_mid();
        $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
        $finish;
    end

endmodule
